match_controller: RTL
=====================

// Module: match_controller
// PURPOSE
//   Match sequencer for the air-hockey game datapath. Decides when the ball moves,
//   when it is re-centred, and which way it is served. Keeps both scores and declares
//   the winner. Sits beside the game/render block: it consumes that block's
//   end-of-frame and wall-hit strobes and drives its ball-run/load controls.
// PARAMETERS
//   WIN_SCORE     7   goals needed to win; must be < 2**SCORE_W
//   SCORE_W       4   width of each score counter
//   SERVE_FRAMES  60  frames the ball sits centred before play starts
//   GOAL_FRAMES   63  frames of miss-flash after a goal (matches 6-bit flash timer)
// PORTS
//   clk         in   1        pixel clock
//   rst         in   1        asynchronous, active-high reset
//   frame_tick  in   1        1-cycle strobe at xpos==0 && ypos==480
//   goal_left   in   1        ball touched left wall (player 1 conceded); level or pulse
//   goal_right  in   1        ball touched right wall (player 2 conceded)
//   start       in   1        start/restart request, already debounced, 1-cycle pulse
//   pause       in   1        pause toggle, 1-cycle pulse
//   ball_run    out  1        datapath may advance ball position this frame
//   ball_load   out  1        1-cycle pulse: datapath re-centres ball (480,300)
//   serve_dir   out  1        ball X direction after load: 1 = rightward, 0 = leftward
//   miss_flash  out  1        high for the whole GOAL state (drives red screen)
//   score1      out  SCORE_W  player 1 goals
//   score2      out  SCORE_W  player 2 goals
//   winner      out  2        00 none, 01 player 1, 10 player 2
//   state_o     out  3        current state code (debug/HUD)
// BEHAVIOUR
//   - All outputs registered. Reset: IDLE; ball_run=0, ball_load=0, serve_dir=1,
//     miss_flash=0, scores=0, winner=00. Reset mid-match discards everything.
//   - States: IDLE, SERVE, PLAY, PAUSED, GOAL, OVER.
//   - IDLE  -start->  SERVE. Clear scores and winner. ball_load=1 for exactly the
//     first cycle of SERVE. serve_dir keeps its value (1 after reset).
//   - SERVE: load timer with SERVE_FRAMES; decrement on frame_tick; at 0 -> PLAY on
//     the same edge. Goals and pause are ignored here.
//   - PLAY: ball_run=1.
//       pause -> PAUSED, ball_run=0 from the next cycle.
//       Goal detect uses the rising edge of goal_* (one registered previous value
//       per input), so a ball lingering at a wall scores once.
//       goal_left edge  -> score2+1, serve_dir=0 (serve toward conceder).
//       goal_right edge -> score1+1, serve_dir=1.
//       Both edges in the same cycle -> no score change, serve_dir unchanged.
//       Any goal edge -> GOAL, ball_run=0 next cycle.
//       Goal and pause in the same cycle: goal wins and pause is dropped.
//   - PAUSED: pause -> PLAY. start -> SERVE with scores kept, ball_load pulse.
//   - GOAL: miss_flash=1. Timer = GOAL_FRAMES, decremented on frame_tick. At 0:
//       if score1==WIN_SCORE: winner=01 -> OVER.
//       else if score2==WIN_SCORE: winner=10 -> OVER.
//       else -> SERVE with ball_load pulse.
//   - OVER: ball_run=0, winner held. start -> SERVE, clear scores/winner, ball_load.
//   - Scores saturate at WIN_SCORE and never wrap. A start in SERVE/PLAY/GOAL is ignored.
//   - Latency: input strobe -> state/output change at the next rising clk edge.
// STRUCTURE
//   - hockey_pkg: state encodings (IDLE=0 SERVE=1 PLAY=2 PAUSED=3 GOAL=4 OVER=5),
//     winner codes, ball centre constants (480,300) shared with the game block.
//   - Sub-module frame_timer (WIDTH=6): load/value inputs, decrements on frame_tick,
//     done flag when the count is 0. One instance, reused by SERVE and GOAL.
//   - FSM with next-state logic in a combinational block; the score and output
//     registers sit in one clocked block with async rst.
// TESTING
//   1. rst pulse, then start -> 1 cycle later state=SERVE and ball_load=1 for exactly
//      1 cycle; after 60 frame_ticks state=PLAY, ball_run=1.
//   2. In PLAY, goal_left held high for 200 cycles -> score2=1 (once), serve_dir=0,
//      miss_flash=1 for 63 frames, then SERVE with ball_load.
//   3. goal_left and goal_right rise on the same cycle -> scores unchanged,
//      serve_dir unchanged, GOAL entered.
//   4. Drive 7 goal_right edges (full serve cycle each) -> score1=7, winner=01,
//      state=OVER; further goals ignored; start -> scores 0, winner 00, SERVE.
//   5. pause in PLAY -> ball_run=0 and goals ignored; pause again -> PLAY;
//      pause+goal on the same cycle -> GOAL and pause dropped.
//   6. Assert rst while in GOAL mid-flash -> immediately IDLE, all outputs at reset values.

Source files
------------

// File: rtl/hockey_pkg.sv
// Shared definitions for the air-hockey datapath: match state codes, winner codes
// and the ball centre position used when the ball is (re)loaded.
package hockey_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_GOAL   = 3'd4,
    ST_OVER   = 3'd5
  } match_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [9:0] BALL_X0 = 10'd480;
  localparam logic [9:0] BALL_Y0 = 10'd300;

endpackage

// File: rtl/frame_timer.sv
// Frame-granular down-counter: load a value, decrement once per frame_tick,
// stop at zero. done = count is 0, last = count is 1 (expires on the next tick).
module frame_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             frame_tick,
  output logic             done,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (frame_tick && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);
  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/match_controller.sv
// Air-hockey match sequencer: serve/play/pause/goal/game-over flow, score keeping
// and winner detection. Every output is a register updated from the next state.
module match_controller
  import hockey_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int GOAL_FRAMES  = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               goal_left,
  input  logic               goal_right,
  input  logic               start,
  input  logic               pause,
  output logic               ball_run,
  output logic               ball_load,
  output logic               serve_dir,
  output logic               miss_flash,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [2:0]         state_o
);

  localparam int TIMER_W = 6;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  match_state_e state, next_state;
  logic goal_l_q, goal_r_q;
  logic edge_l, edge_r;
  logic tmr_load, tmr_done, tmr_last, tmr_expire;
  logic [TIMER_W-1:0] tmr_value;
  logic clear_match;

  // Rising-edge detect so a ball resting against a wall scores only once.
  assign edge_l = goal_left & ~goal_l_q;
  assign edge_r = goal_right & ~goal_r_q;

  // The timer reaches zero on this edge, or is already sitting at zero.
  assign tmr_expire = tmr_done | (frame_tick & tmr_last);

  assign tmr_load    = (next_state != state) &&
                       (next_state == ST_SERVE || next_state == ST_GOAL);
  assign tmr_value   = (next_state == ST_GOAL) ? TIMER_W'(GOAL_FRAMES)
                                               : TIMER_W'(SERVE_FRAMES);
  assign clear_match = start && (state == ST_IDLE || state == ST_OVER);

  frame_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .value      (tmr_value),
    .frame_tick (frame_tick),
    .done       (tmr_done),
    .last       (tmr_last)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_SERVE;
      ST_SERVE:  if (tmr_expire) next_state = ST_PLAY;
      ST_PLAY: begin
        if (edge_l || edge_r) next_state = ST_GOAL;
        else if (pause)       next_state = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (pause)      next_state = ST_PLAY;
        else if (start) next_state = ST_SERVE;
      end
      ST_GOAL: begin
        if (tmr_expire) begin
          if (score1 == WIN || score2 == WIN) next_state = ST_OVER;
          else                                next_state = ST_SERVE;
        end
      end
      ST_OVER:   if (start) next_state = ST_SERVE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_run   <= 1'b0;
      ball_load  <= 1'b0;
      serve_dir  <= 1'b1;
      miss_flash <= 1'b0;
      score1     <= '0;
      score2     <= '0;
      winner     <= WIN_NONE;
      goal_l_q   <= 1'b0;
      goal_r_q   <= 1'b0;
    end else begin
      ball_run   <= (next_state == ST_PLAY);
      ball_load  <= (next_state == ST_SERVE) && (state != ST_SERVE);
      miss_flash <= (next_state == ST_GOAL);
      goal_l_q   <= goal_left;
      goal_r_q   <= goal_right;
      if (clear_match) begin
        score1 <= '0;
        score2 <= '0;
        winner <= WIN_NONE;
      end else if (state == ST_PLAY && edge_l && !edge_r) begin
        // Left wall hit: player 2 scores, next serve heads toward player 1.
        if (score2 < WIN) score2 <= score2 + SCORE_W'(1);
        serve_dir <= 1'b0;
      end else if (state == ST_PLAY && edge_r && !edge_l) begin
        if (score1 < WIN) score1 <= score1 + SCORE_W'(1);
        serve_dir <= 1'b1;
      end
      if (state == ST_GOAL && tmr_expire) begin
        if (score1 == WIN)      winner <= WIN_P1;
        else if (score2 == WIN) winner <= WIN_P2;
      end
    end
  end

  assign state_o = state;

endmodule
